// File: rtl/ndro_pkg.sv
// ============================================================================
// Module      : ndro_pkg
// Description : Shared types and parameter limits for the NDRO storage bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ndro_pkg;

    typedef enum logic {
        NDRO = 1'b0,
        DRO  = 1'b1
    } mode_e;

    localparam int CH_MAX    = 64;
    localparam int DELAY_MAX = 16;
    localparam int PW_MAX    = 8;

    // Width of a counter that must hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : ndro_pkg

`default_nettype wire

// File: rtl/ndro_chan.sv
// ============================================================================
// Module      : ndro_chan
// Description : One NDRO/DRO storage channel: state bit, violation flags,
//               read-latency pipeline and output pulse stretcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ndro_chan
    import ndro_pkg::*;
#(
    parameter int    DELAY   = 3,
    parameter int    PULSE_W = 2,
    parameter mode_e MODE    = NDRO
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic clr,
    input  logic rd,
    output logic dout,
    output logic state_o,
    output logic dup_o,
    output logic su_viol_o
);

    localparam int             CW    = cnt_width(PULSE_W);
    localparam logic [CW-1:0]  C_PW  = CW'(PULSE_W);
    localparam logic [CW-1:0]  C_ONE = CW'(1);

    logic             state_q, state_d;
    logic             dup_q,   dup_d;
    logic             su_q,    su_d;
    logic [DELAY-1:0] pipe_q,  pipe_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             samp;
    logic             pipe_out;

    // The read sees the pre-edge state, so a coincident din or clr never
    // changes what this read emits.
    assign samp     = rd & state_q;
    assign pipe_out = pipe_q[DELAY-1];

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = 1'b0;
        end else if (din) begin
            state_d = 1'b1;
        end else if (rd && (MODE == DRO)) begin
            state_d = 1'b0;
        end
    end

    always_comb begin
        dup_d = din & state_q & ~clr;
        su_d  = din & rd & ~state_q;
    end

    generate
        if (DELAY == 1) begin : g_pipe_single
            assign pipe_d = samp;
        end else begin : g_pipe_multi
            assign pipe_d = {pipe_q[DELAY-2:0], samp};
        end
    endgenerate

    // A retrigger reloads the full width, so merged pulses never show a gap.
    always_comb begin
        cnt_d = cnt_q;
        if (pipe_out) begin
            cnt_d = C_PW;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= 1'b0;
            dup_q   <= 1'b0;
            su_q    <= 1'b0;
            pipe_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dup_q   <= dup_d;
            su_q    <= su_d;
            pipe_q  <= pipe_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout      = (cnt_q != '0);
    assign state_o   = state_q;
    assign dup_o     = dup_q;
    assign su_viol_o = su_q;

endmodule : ndro_chan

`default_nettype wire

// File: rtl/ndro_bank.sv
// ============================================================================
// Module      : ndro_bank
// Description : Bank of CH non-destructive-readout cells sharing one read
//               strobe, with programmable latency and output pulse width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ndro_bank
    import ndro_pkg::*;
#(
    parameter int    CH      = 8,
    parameter int    DELAY   = 3,
    parameter int    PULSE_W = 2,
    parameter mode_e MODE    = NDRO
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] din,
    input  logic [CH-1:0] clr,
    input  logic          rd,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] state_o,
    output logic [CH-1:0] dup_o,
    output logic [CH-1:0] su_viol_o
);

    generate
        if (CH < 1 || CH > CH_MAX) begin : g_bad_ch
            $error("ndro_bank: CH=%0d outside 1..%0d", CH, CH_MAX);
        end
        if (DELAY < 1 || DELAY > DELAY_MAX) begin : g_bad_delay
            $error("ndro_bank: DELAY=%0d outside 1..%0d", DELAY, DELAY_MAX);
        end
        if (PULSE_W < 1 || PULSE_W > PW_MAX) begin : g_bad_pw
            $error("ndro_bank: PULSE_W=%0d outside 1..%0d", PULSE_W, PW_MAX);
        end
    endgenerate

    generate
        for (genvar i = 0; i < CH; i++) begin : g_chan
            ndro_chan #(
                .DELAY   (DELAY),
                .PULSE_W (PULSE_W),
                .MODE    (MODE)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .din       (din[i]),
                .clr       (clr[i]),
                .rd        (rd),
                .dout      (dout[i]),
                .state_o   (state_o[i]),
                .dup_o     (dup_o[i]),
                .su_viol_o (su_viol_o[i])
            );
        end
    endgenerate

endmodule : ndro_bank

`default_nettype wire

// File: tb/tb_ndro_bank.sv
// ============================================================================
// Module      : tb_ndro_bank
// Description : Randomised self-checking bench for ndro_bank, NDRO and DRO
//               instances driven in lockstep against a read-history model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ndro_bank;

    localparam int CH      = 8;
    localparam int DELAY   = 3;
    localparam int PULSE_W = 2;
    localparam int HIST    = 4096;
    localparam int NRAND   = 2500;

    logic          clk;
    logic          reset;
    logic [CH-1:0] din;
    logic [CH-1:0] clr;
    logic          rd;

    logic [CH-1:0] dout_n, state_n, dup_n, su_n;
    logic [CH-1:0] dout_d, state_d, dup_d, su_d;

    int n_checks = 0;
    int n_errors = 0;

    // Model: stored state per mode, and for every edge the vector of set
    // channels that a read captured at that edge.
    logic [CH-1:0] m_s_n, m_s_d;
    logic [CH-1:0] m_dup_n, m_dup_d, m_su_n, m_su_d;
    logic [CH-1:0] hist_n [HIST];
    logic [CH-1:0] hist_d [HIST];
    int            last_rst;
    int            t;

    ndro_bank #(
        .CH(CH), .DELAY(DELAY), .PULSE_W(PULSE_W), .MODE(ndro_pkg::NDRO)
    ) u_dut_ndro (
        .clk(clk), .reset(reset), .din(din), .clr(clr), .rd(rd),
        .dout(dout_n), .state_o(state_n), .dup_o(dup_n), .su_viol_o(su_n)
    );

    ndro_bank #(
        .CH(CH), .DELAY(DELAY), .PULSE_W(PULSE_W), .MODE(ndro_pkg::DRO)
    ) u_dut_dro (
        .clk(clk), .reset(reset), .din(din), .clr(clr), .rd(rd),
        .dout(dout_d), .state_o(state_d), .dup_o(dup_d), .su_viol_o(su_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    // A read captured at edge T drives dout during T+DELAY .. T+DELAY+PULSE_W-1,
    // unless a reset edge lies after it.
    function automatic logic [CH-1:0] exp_dout(input logic dro, input int now);
        logic [CH-1:0] acc;
        acc = '0;
        for (int k = now - DELAY - PULSE_W + 1; k <= now - DELAY; k++) begin
            if (k >= 0 && k > last_rst)
                acc |= dro ? hist_d[k] : hist_n[k];
        end
        return acc;
    endfunction

    function automatic logic [CH-1:0] next_state(input logic [CH-1:0] s, input logic dro);
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) begin
            if (clr[i])               r[i] = 1'b0;
            else if (din[i])          r[i] = 1'b1;
            else if (rd && dro)       r[i] = 1'b0;
            else                      r[i] = s[i];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) begin
            m_s_n = '0; m_s_d = '0;
            m_dup_n = '0; m_dup_d = '0; m_su_n = '0; m_su_d = '0;
            hist_n[t] = '0; hist_d[t] = '0;
            last_rst = t;
        end else begin
            hist_n[t] = rd ? m_s_n : '0;
            hist_d[t] = rd ? m_s_d : '0;
            m_dup_n = din & m_s_n & ~clr;
            m_dup_d = din & m_s_d & ~clr;
            m_su_n  = rd ? (din & ~m_s_n) : '0;
            m_su_d  = rd ? (din & ~m_s_d) : '0;
            m_s_n   = next_state(m_s_n, 1'b0);
            m_s_d   = next_state(m_s_d, 1'b1);
        end
        #1;
        chk("ndro_state", 64'(state_n), 64'(m_s_n));
        chk("ndro_dout",  64'(dout_n),  64'(exp_dout(1'b0, t)));
        chk("ndro_dup",   64'(dup_n),   64'(m_dup_n));
        chk("ndro_suv",   64'(su_n),    64'(m_su_n));
        chk("dro_state",  64'(state_d), 64'(m_s_d));
        chk("dro_dout",   64'(dout_d),  64'(exp_dout(1'b1, t)));
        chk("dro_dup",    64'(dup_d),   64'(m_dup_d));
        chk("dro_suv",    64'(su_d),    64'(m_su_d));
        t++;
    endtask

    task automatic drive(input logic [CH-1:0] d, input logic [CH-1:0] c,
                         input logic r, input logic rstn, input int cycles);
        din = d; clr = c; rd = r; reset = rstn;
        for (int k = 0; k < cycles; k++) step();
    endtask

    initial begin
        t = 0; last_rst = -1;
        m_s_n = '0; m_s_d = '0;
        m_dup_n = '0; m_dup_d = '0; m_su_n = '0; m_su_d = '0;
        din = '1; clr = '0; rd = 1'b0; reset = 1'b0;

        // Reset held with all sets asserted.
        drive('1, '0, 1'b0, 1'b0, 2);

        // Basic read: set ch3, two reads four cycles apart.
        drive(8'h08, '0, 1'b0, 1'b1, 1);
        drive('0,    '0, 1'b0, 1'b1, 1);
        drive('0,    '0, 1'b1, 1'b1, 1);
        drive('0,    '0, 1'b0, 1'b1, 3);
        drive('0,    '0, 1'b1, 1'b1, 1);
        drive('0,    '0, 1'b0, 1'b1, 7);

        // Coincident events on channels 0..2.
        drive(8'h01, '0,    1'b1, 1'b1, 1);
        drive(8'h02, 8'h02, 1'b0, 1'b1, 1);
        drive(8'h04, '0,    1'b0, 1'b1, 1);
        drive('0,    8'h04, 1'b1, 1'b1, 1);
        drive('0,    '0,    1'b0, 1'b1, 6);

        // Duplicate set then back-to-back reads on channel 5.
        drive(8'h20, '0, 1'b0, 1'b1, 2);
        drive('0,    '0, 1'b0, 1'b1, 1);
        drive('0,    '0, 1'b1, 1'b1, 2);
        drive('0,    '0, 1'b0, 1'b1, 7);

        // Reset while a read is in flight.
        drive(8'h40, '0, 1'b0, 1'b1, 2);
        drive('0,    '0, 1'b1, 1'b1, 1);
        drive('0,    '0, 1'b0, 1'b0, 1);
        drive('0,    '0, 1'b0, 1'b1, 8);

        for (int n = 0; n < NRAND; n++) begin
            logic [CH-1:0] rd_din, rd_clr;
            rd_din = '0; rd_clr = '0;
            for (int i = 0; i < CH; i++) begin
                rd_din[i] = ($urandom_range(0, 3) == 0);
                rd_clr[i] = ($urandom_range(0, 7) == 0);
            end
            drive(rd_din, rd_clr, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 59) != 0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ndro_bank

`default_nettype wire
